mul_seq: RTL and testbench

Sequencer for the PDP-11 MUL instruction, sitting between the execute-stage decode and the 16x16 signed multiplier. It latches the operands, holds them and `mul_ready` to the multiplier, and captures the 32-bit product and overflow on `mul_done`. It then writes the result back through the single register-file write port using PDP-11 even/odd destination rules, and issues the N/Z/V/C condition codes.

---
 rtl/mul_seq.sv | 191 +++++++++++++++++++
 tb/tb_mul_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: PDP-11 MUL sequencer.
// Latches the operands, hands them to the external 16x16 signed multiplier,
// captures the 32-bit product, and writes it back through the single
// register-file port using the PDP-11 even/odd destination rules. It then
// issues one N/Z/V/C update.
// Optional feature macro: MULSEQ_ZERO_BYPASS_EN. When it is defined, a zero
// operand skips the multiplier and the sequencer writes P=0 directly.
// All outputs are registers. They are decoded from the state the FSM is about
// to enter, so each output changes on the same edge as the state.
`timescale 1ns/1ps
module mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  dst_reg,
  input  logic [15:0] src_a,
  input  logic [15:0] src_b,
  output logic        mul_ready,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_product,
  input  logic        mul_overflow,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  input  logic        rf_stall,
  output logic        cc_we,
  output logic [3:0]  cc_nzvc,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_HI = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [2:0]  dst_q, dst_d;
  logic [31:0] p_q, p_d;
  logic        ov_q, ov_d;
  logic        mul_ready_q, mul_ready_d;
  logic        busy_q, busy_d;
  logic        rf_we_q, rf_we_d;
  logic [2:0]  rf_waddr_q, rf_waddr_d;
  logic [15:0] rf_wdata_q, rf_wdata_d;
  logic        cc_we_q, cc_we_d;
  logic [3:0]  cc_nzvc_q, cc_nzvc_d;
  logic        done_q, done_d;
  logic        zero_op_s;

  // N from the product sign, Z from an all-zero product, V always clear,
  // C from the multiplier overflow flag.
  function automatic logic [3:0] calc_nzvc(input logic [31:0] p, input logic ov);
    calc_nzvc = {p[31], (p == 32'd0), 1'b0, ov};
  endfunction

`ifdef MULSEQ_ZERO_BYPASS_EN
  assign zero_op_s = (src_a == 16'd0) || (src_b == 16'd0);
`else
  assign zero_op_s = 1'b0;
`endif

  // Sequencer transitions and capture of operands and product.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    p_d     = p_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = src_a;
          b_d   = src_b;
          dst_d = dst_reg;
          if (zero_op_s) begin
            p_d     = 32'd0;
            ov_d    = 1'b0;
            state_d = dst_reg[0] ? S_WR_LO : S_WR_HI;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mul_done) begin
          p_d     = mul_product;
          ov_d    = mul_overflow;
          state_d = dst_q[0] ? S_WR_LO : S_WR_HI;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WR_HI: begin
        if (!rf_stall) begin
          state_d = S_WR_LO;
        end else begin
          state_d = S_WR_HI;
        end
      end
      S_WR_LO: begin
        if (!rf_stall) begin
          state_d = S_FIN;
        end else begin
          state_d = S_WR_LO;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state. During a stall the state does not
  // change, so the write port holds its values.
  always_comb begin
    mul_ready_d = (state_d == S_WAIT);
    busy_d      = (state_d != S_IDLE);
    rf_we_d     = (state_d == S_WR_HI) || (state_d == S_WR_LO);
    done_d      = (state_d == S_FIN);
    cc_we_d     = (state_d == S_FIN);
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    cc_nzvc_d   = cc_nzvc_q;
    case (state_d)
      S_WR_HI: begin
        rf_waddr_d = dst_d;
        rf_wdata_d = p_d[31:16];
      end
      S_WR_LO: begin
        rf_waddr_d = {dst_d[2:1], 1'b1};
        rf_wdata_d = p_d[15:0];
      end
      S_FIN:   cc_nzvc_d = calc_nzvc(p_d, ov_d);
      default: cc_nzvc_d = cc_nzvc_q;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      dst_q       <= 3'd0;
      p_q         <= 32'd0;
      ov_q        <= 1'b0;
      mul_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 3'd0;
      rf_wdata_q  <= 16'd0;
      cc_we_q     <= 1'b0;
      cc_nzvc_q   <= 4'b0000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dst_q       <= dst_d;
      p_q         <= p_d;
      ov_q        <= ov_d;
      mul_ready_q <= mul_ready_d;
      busy_q      <= busy_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      cc_we_q     <= cc_we_d;
      cc_nzvc_q   <= cc_nzvc_d;
      done_q      <= done_d;
    end
  end

  assign mul_ready = mul_ready_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign cc_we     = cc_we_q;
  assign cc_nzvc   = cc_nzvc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq. It uses a behavioural multiplier with
// random latency and an arithmetic reference for the expected register writes,
// condition codes and latency.
`timescale 1ns/1ps
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  dst_reg;
  logic [15:0] src_a, src_b;
  logic        mul_ready;
  logic [15:0] mul_a, mul_b;
  logic        mul_done;
  logic [31:0] mul_product;
  logic        mul_overflow;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_stall;
  logic        cc_we;
  logic [3:0]  cc_nzvc;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int mul_lat = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dst_reg(dst_reg),
    .src_a(src_a), .src_b(src_b), .mul_ready(mul_ready), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
    .mul_overflow(mul_overflow), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_stall(rf_stall), .cc_we(cc_we),
    .cc_nzvc(cc_nzvc), .busy(busy), .done(done)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Multiplier model: while requested, wait mul_lat cycles, then pulse the result.
  initial begin
    int prod;
    mul_done = 1'b0;
    mul_product = 32'd0;
    mul_overflow = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mul_done) begin
        mul_done = 1'b0;
      end else if (mul_ready) begin
        if (wait_cnt >= mul_lat) begin
          prod = int'($signed(mul_a)) * int'($signed(mul_b));
          mul_product = prod;
          mul_overflow = (prod > 32767) || (prod < -32768);
          mul_done = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic run_op(input logic [2:0] dst, input logic [15:0] a, input logic [15:0] b,
                        input int nstall, input bit inject, input int lat);
    int prod, j, d, done_j, stall_left, nwr, exp_done;
    bit ov, bypass, ready_seen, prev_stall;
    logic [2:0]  prev_addr;
    logic [15:0] prev_data;
    logic [3:0]  exp_cc;
    logic [2:0]  ea[$];
    logic [15:0] ed[$];
    prod = int'($signed(a)) * int'($signed(b));
    ov = (prod > 32767) || (prod < -32768);
    exp_cc = {prod[31], (prod == 0), 1'b0, ov};
    if (dst[0] == 1'b0) begin
      ea.push_back(dst);         ed.push_back(prod[31:16]);
      ea.push_back(dst | 3'd1);  ed.push_back(prod[15:0]);
    end else begin
      ea.push_back(dst);         ed.push_back(prod[15:0]);
    end
`ifdef MULSEQ_ZERO_BYPASS_EN
    bypass = (a == 16'd0) || (b == 16'd0);
`else
    bypass = 1'b0;
`endif
    mul_lat = lat;
    @(negedge clk);
    start = 1'b1; dst_reg = dst; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = 16'($urandom); src_b = 16'($urandom); dst_reg = 3'($urandom);
    j = 0; d = -1; done_j = -1; stall_left = nstall; nwr = 0;
    prev_stall = 1'b0; ready_seen = 1'b0; prev_addr = 3'd0; prev_data = 16'd0;
    chk_val("busy_start", busy, 1);
    while (done_j < 0 && j < 200) begin
      start = inject && (j == 1);
      if (start) begin
        src_a = 16'($urandom); src_b = 16'($urandom); dst_reg = ~dst;
      end
      if (mul_ready) begin
        ready_seen = 1'b1;
        chk_val("mul_a", mul_a, a);
        chk_val("mul_b", mul_b, b);
      end
      if (mul_done && d < 0) d = j + 1;
      if (prev_stall) begin
        chk_val("stall_we", rf_we, 1);
        chk_val("stall_addr", rf_waddr, prev_addr);
        chk_val("stall_data", rf_wdata, prev_data);
      end
      rf_stall = rf_we && (stall_left > 0);
      if (rf_stall) stall_left--;
      prev_stall = rf_stall; prev_addr = rf_waddr; prev_data = rf_wdata;
      if (rf_we && !rf_stall) begin
        if (nwr < ea.size()) begin
          chk_val("wr_addr", rf_waddr, ea[nwr]);
          chk_val("wr_data", rf_wdata, ed[nwr]);
        end
        nwr++;
      end
      if (done) begin
        done_j = j;
        chk_val("cc_we", cc_we, 1);
        chk_val("cc_nzvc", cc_nzvc, exp_cc);
        chk_val("busy_fin", busy, 1);
      end
      @(negedge clk);
      j++;
    end
    start = 1'b0; rf_stall = 1'b0;
    chk_val("done_seen", done_j >= 0, 1);
    if (!bypass) chk_val("mul_done_seen", d > 0, 1);
    exp_done = (bypass ? 0 : d) + (dst[0] ? 1 : 2) + nstall;
    chk_val("latency", done_j, exp_done);
    chk_val("nwrites", nwr, ea.size());
    chk_val("ready_seen", ready_seen, !bypass);
    chk_val("idle_busy", busy, 0);
    chk_val("idle_done", done, 0);
    chk_val("idle_cc_we", cc_we, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; dst_reg = 3'd0; src_a = 16'd0; src_b = 16'd0; rf_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_mul_ready", mul_ready, 0);
    chk_val("rst_mul_a", mul_a, 0);
    chk_val("rst_mul_b", mul_b, 0);
    chk_val("rst_rf_we", rf_we, 0);
    chk_val("rst_rf_waddr", rf_waddr, 0);
    chk_val("rst_rf_wdata", rf_wdata, 0);
    chk_val("rst_cc_we", cc_we, 0);
    chk_val("rst_cc_nzvc", cc_nzvc, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(3'd2, 16'd300, 16'hFF38, 0, 1'b0, 2);
    run_op(3'd5, 16'd7, 16'd6, 0, 1'b0, 1);
    run_op(3'd0, 16'hFFFF, 16'hFFFF, 3, 1'b0, 0);
    run_op(3'd6, 16'd1234, 16'hFFFB, 0, 1'b1, 3);
    run_op(3'd7, 16'h8000, 16'd1, 0, 1'b0, 0);
    run_op(3'd0, 16'h8000, 16'h8000, 1, 1'b0, 4);

    // Reset in the middle of WAIT.
    mul_lat = 20;
    @(negedge clk);
    start = 1'b1; dst_reg = 3'd6; src_a = 16'd11; src_b = 16'd13;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_val("rst_pre_ready", mul_ready, 1);
    #2 reset_n = 1'b0;
    #1;
    chk_val("rst_mid_ready", mul_ready, 0);
    chk_val("rst_mid_busy", busy, 0);
    chk_val("rst_mid_we", rf_we, 0);
    chk_val("rst_mid_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_val("post_rst_we", rf_we, 0);
      chk_val("post_rst_done", done, 0);
      chk_val("post_rst_ready", mul_ready, 0);
    end
    run_op(3'd3, 16'd100, 16'd200, 0, 1'b0, 1);

    run_op(3'd4, 16'd5, 16'd0, 0, 1'b0, 1);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 4) == 0) ra = 16'd0;
      if ($urandom_range(0, 4) == 0) rb = 16'd0;
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
